// File: rtl/jedro_1_shift_cmp_unit.sv
// Registered shift/compare unit for the jedro_1 ALU: SLL/SRL/SRA barrel shifts
// plus signed/unsigned set-less-than, presented one cycle after a request.
module jedro_1_shift_cmp_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [2:0]            op_sel_i,
  input  logic [DATA_WIDTH-1:0] opa_i,
  input  logic [DATA_WIDTH-1:0] opb_i,
  output logic [DATA_WIDTH-1:0] res_o,
  output logic                  valid_o
);

  // Handshake: valid_i is a one-cycle request strobe with no ready/backpressure;
  // every request accepted at edge N yields valid_o=1 for exactly the cycle after N.

  localparam logic [2:0] OP_SLL  = 3'b000;
  localparam logic [2:0] OP_SRL  = 3'b001;
  localparam logic [2:0] OP_SRA  = 3'b010;
  localparam logic [2:0] OP_SLT  = 3'b011;
  localparam logic [2:0] OP_SLTU = 3'b100;

  logic [4:0]                 shamt;
  logic                       fill_bit;
  logic [5:0][DATA_WIDTH-1:0] sl_st;
  logic [5:0][DATA_WIDTH-1:0] sr_st;
  logic                       slt_bit;
  logic                       sltu_bit;
  logic [DATA_WIDTH-1:0]      res_next;

  // The shift amount is fixed at 5 bits, so only DATA_WIDTH = 32 is meaningful.
  assign shamt    = opb_i[4:0];
  assign fill_bit = (op_sel_i == OP_SRA) & opa_i[DATA_WIDTH-1];

  assign sl_st[0] = opa_i;
  assign sr_st[0] = opa_i;

  for (genvar s = 0; s < 5; s++) begin : g_stage
    localparam int SH = 1 << s;
    assign sl_st[s+1] = shamt[s] ? {sl_st[s][DATA_WIDTH-1-SH:0], {SH{1'b0}}} : sl_st[s];
    assign sr_st[s+1] = shamt[s] ? {{SH{fill_bit}}, sr_st[s][DATA_WIDTH-1:SH]} : sr_st[s];
  end

  assign slt_bit  = $signed(opa_i) < $signed(opb_i);
  assign sltu_bit = opa_i < opb_i;

  always_comb begin
    res_next = '0;
    case (op_sel_i)
      OP_SLL:  res_next = sl_st[5];
      OP_SRL,
      OP_SRA:  res_next = sr_st[5];
      OP_SLT:  res_next = {{(DATA_WIDTH-1){1'b0}}, slt_bit};
      OP_SLTU: res_next = {{(DATA_WIDTH-1){1'b0}}, sltu_bit};
      default: res_next = '0;
    endcase
  end

  // Reset wins over a same-cycle request; idle cycles hold the last result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_o   <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        res_o <= res_next;
      end
    end
  end

endmodule

// File: tb/tb_jedro_1_shift_cmp_unit.sv
// Bench for jedro_1_shift_cmp_unit: directed vectors with fixed expectations,
// then randomized traffic scored against an arithmetic reference model.
module tb_jedro_1_shift_cmp_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [2:0]  op_sel_i = 3'b000;
  logic [31:0] opa_i = '0;
  logic [31:0] opb_i = '0;
  logic [31:0] res_o;
  logic        valid_o;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] exp_q[$];
  logic [31:0] hold_val = '0;
  logic        mon_en = 1'b0;
  logic        dir_use = 1'b0;
  logic [31:0] dir_exp = '0;

  jedro_1_shift_cmp_unit #(.DATA_WIDTH(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .op_sel_i (op_sel_i),
    .opa_i    (opa_i),
    .opb_i    (opb_i),
    .res_o    (res_o),
    .valid_o  (valid_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int sh;
    logic signed [31:0] sa;
    sh = int'(b % 32);
    sa = a;
    case (op)
      3'd0:    return a << sh;
      3'd1:    return a >> sh;
      3'd2:    return sa >>> sh;
      3'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4:    return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // scoreboard: capture accepted requests at the edge, check outputs at the falling edge
  always @(posedge clk_i) begin
    if (rst_i) begin
      exp_q.delete();
      hold_val = '0;
      mon_en   = 1'b1;
    end else if (valid_i) begin
      exp_q.push_back(dir_use ? dir_exp : ref_result(op_sel_i, opa_i, opb_i));
    end
  end

  always @(negedge clk_i) begin
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("valid_o_new", {31'b0, valid_o}, 32'd1);
        check("res_o", res_o, e);
        hold_val = e;
      end else begin
        check("valid_o_idle", {31'b0, valid_o}, 32'd0);
        check("res_o_hold", res_o, hold_val);
      end
    end
  end

  // driver tasks
  task automatic drive(input logic v, input logic r, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    dir_use  = 1'b0;
    rst_i    = r;
    valid_i  = v;
    op_sel_i = op;
    opa_i    = a;
    opb_i    = b;
  endtask

  task automatic drive_dir(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e);
    drive(1'b1, 1'b0, op, a, b);
    dir_use = 1'b1;
    dir_exp = e;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'd0, $urandom, $urandom);
  endtask

  initial begin
    // reset held two cycles with a live request that must be dropped
    drive(1'b1, 1'b1, 3'd0, 32'd1, 32'd1);
    drive(1'b1, 1'b1, 3'd0, 32'd1, 32'd1);
    idle(1);

    drive_dir(3'd0, 32'h8000_0001, 32'd4, 32'h0000_0010);
    drive_dir(3'd1, 32'h8000_0001, 32'd4, 32'h0800_0000);
    drive_dir(3'd2, 32'h8000_0001, 32'd4, 32'hF800_0000);
    drive_dir(3'd2, 32'h7FFF_FFFF, 32'd31, 32'h0000_0000);
    drive_dir(3'd0, 32'h0000_0001, 32'd31, 32'h8000_0000);
    drive_dir(3'd0, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678);
    drive_dir(3'd1, 32'h1234_5678, 32'hFFFF_FFE1, 32'h091A_2B3C);
    drive_dir(3'd3, 32'hFFFF_FFFF, 32'd1, 32'd1);
    drive_dir(3'd4, 32'hFFFF_FFFF, 32'd1, 32'd0);
    drive_dir(3'd3, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1);
    drive_dir(3'd4, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0);
    drive_dir(3'd3, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0);
    drive_dir(3'd4, 32'h7FFF_FFFF, 32'h8000_0000, 32'd1);
    drive_dir(3'd3, 32'hFFFF_FFFF, 32'h0000_0000, 32'd1);
    drive_dir(3'd4, 32'hFFFF_FFFF, 32'h0000_0000, 32'd0);
    drive_dir(3'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd0);
    drive_dir(3'd4, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd0);
    idle(1);

    // three back-to-back results, then idle: res_o must hold the SLT result
    drive_dir(3'd0, 32'h0000_0003, 32'd2, 32'h0000_000C);
    drive_dir(3'd2, 32'h8000_0000, 32'd1, 32'hC000_0000);
    drive_dir(3'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1);
    idle(3);
    drive_dir(3'd7, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0);
    drive_dir(3'd5, 32'h1234_5678, 32'h0000_0003, 32'd0);
    idle(1);

    // reset mid-stream discards the in-flight result and clears res_o
    drive_dir(3'd0, 32'h0000_00FF, 32'd8, 32'h0000_FF00);
    drive(1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF, 32'd0);
    idle(2);

    // randomized traffic with gaps and occasional resets
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h8000_0000;
        1: b = a;
        2: b = {$urandom_range(0, 1) ? 27'h7FF_FFFF : 27'h0, 5'($urandom_range(0, 31))};
        default: ;
      endcase
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
            3'($urandom_range(0, 7)), a, b);
    end
    idle(3);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/jedro_1_shift_cmp_unit.md
Name: jedro_1_shift_cmp_unit

Overview:
- Registered shift/compare execution unit for the jedro_1 RV32I core.
- Computes the logical left shift, logical right shift, arithmetic right shift, signed less-than and unsigned less-than results.
- Presents the selected result one clock after a valid request.
- Sits beside the adder/logic datapath in the ALU; the ALU result mux consumes res_o.

Parameters:
- DATA_WIDTH, 32, operand and result width. Only 32 is supported, because the shift amount is a fixed 5 bits.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- valid_i  input  1  request strobe; operands and op are sampled when high.
- op_sel_i  input  3  operation select (encoding below).
- opa_i  input  32  operand A; the value shifted, or the left-hand side of the compare.
- opb_i  input  32  operand B; bits [4:0] are the shift amount, or the full word is the right-hand side of the compare.
- res_o  output  32  registered result.
- valid_o  output  1  high for exactly one cycle when res_o carries a new result.

Behaviour:
- op_sel_i encoding:
  - 3'b000 SLL
  - 3'b001 SRL
  - 3'b010 SRA
  - 3'b011 SLT (signed)
  - 3'b100 SLTU (unsigned)
  - 3'b101 to 3'b111 reserved; the result is 32'h0.
- Shift amount: shamt = opb_i[4:0]. Bits opb_i[31:5] are ignored, so a shift by 32 behaves as a shift by 0.
- Shifts are pure combinational barrel shifters, implemented as 5 stages (1, 2, 4, 8, 16) selected by the shamt bits. No iterative or multi-cycle shifting.
- SLL: zeros fill from the LSB side.
- SRL: zeros fill from the MSB side.
- SRA: copies of opa_i[31] fill from the MSB side.
- SRL and SRA share one right shifter. Its fill bit is (op is SRA) & opa_i[31].
- SLT compares two's-complement values; the result is {31'b0, opa < opb}.
- SLTU compares unsigned values; the result is {31'b0, opa < opb}.
- Equal operands give 0 for both compares.
- Both compares are combinational and must be correct at every boundary: most-negative vs most-positive, and -1 vs 0.
- Latency is 1 cycle. If valid_i is high at edge N, then after edge N: res_o = f(op, opa, opb) and valid_o = 1.
- If valid_i is low at an edge: res_o holds its previous value and valid_o = 0.
- Back-to-back valid_i on consecutive cycles gives a result every cycle. There is no backpressure and no stall.
- Reset: when rst_i is high at an edge, res_o is 32'h0 and valid_o is 0 after that edge.
  - Reset dominates valid_i.
  - A request sampled in the same cycle as reset is dropped.
  - Reset mid-stream discards any in-flight result.
- No X propagation from reserved op codes; they produce 0 with valid_o = 1.

Test Plan:
- Reset: hold rst_i = 1 for 2 cycles with valid_i = 1 and op SLL, opa = 1, opb = 1 -> res_o = 0, valid_o = 0. Release reset -> the next valid request produces a result 1 cycle later.
- Shifts with opa = 32'h8000_0001, opb = 4:
  - SLL -> 32'h0000_0010
  - SRL -> 32'h0800_0000
  - SRA -> 32'hF800_0000
- SRA with opa = 32'h7FFF_FFFF, opb = 31 -> 32'h0000_0000. SLL with opa = 1, opb = 31 -> 32'h8000_0000.
- Shift amount masking: SLL with opa = 32'h1234_5678, opb = 32'h0000_0020 -> 32'h1234_5678. SRL with opb = 32'hFFFF_FFE1 (shamt 1) -> 32'h091A_2B3C.
- Compares:
  - SLT opa = 32'hFFFF_FFFF, opb = 1 -> 1; SLTU same operands -> 0.
  - SLT 32'h8000_0000 vs 32'h7FFF_FFFF -> 1; SLTU same operands -> 0.
  - Equal operands, both ops -> 0.
- Pipelining: valid_i on 3 consecutive cycles (SLL, SRA, SLT), then low -> three back-to-back results on valid_o. After that valid_o = 0 and res_o holds the SLT result. A reserved op (3'b111) -> res_o = 0.
